// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the FFT sample streamer and its capture side.
// Holds the run FSM states and the AXI4-Stream data beat layout.
package fft_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam int DEF_FRAME_LEN = 8192;
    localparam logic [7:0] DEF_CFG_WORD = 8'h01;

    localparam int RE_LSB = 0;
    localparam int RE_MSB = 31;
    localparam int IM_LSB = 32;
    localparam int IM_MSB = 63;

    function automatic logic [63:0] pack_beat(input logic [31:0] re);
        logic [63:0] b;
        b = '0;
        b[RE_MSB:RE_LSB] = re;
        b[IM_MSB:IM_LSB] = '0;
        return b;
    endfunction

endpackage

// File: rtl/fft_sample_streamer_if.sv
// Control, sample memory and AXI4-Stream signals of the FFT sample streamer.
// master = streamer side, slave = memory / FFT core / controller side.
interface fft_sample_streamer_if #(
    parameter int ADDR_W   = 16,
    parameter int SAMPLE_W = 16
);
    logic                start;
    logic [7:0]          num_frames;
    logic                busy;
    logic                done;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_rdata;
    logic [7:0]          m_axis_config_tdata;
    logic                m_axis_config_tvalid;
    logic                m_axis_config_tready;
    logic [63:0]         m_axis_data_tdata;
    logic                m_axis_data_tvalid;
    logic                m_axis_data_tready;
    logic                m_axis_data_tlast;

    modport master (
        input  start, num_frames, mem_rdata,
        input  m_axis_config_tready, m_axis_data_tready,
        output busy, done, mem_en, mem_addr,
        output m_axis_config_tdata, m_axis_config_tvalid,
        output m_axis_data_tdata, m_axis_data_tvalid,
        output m_axis_data_tlast
    );

    modport slave (
        output start, num_frames, mem_rdata,
        output m_axis_config_tready, m_axis_data_tready,
        input  busy, done, mem_en, mem_addr,
        input  m_axis_config_tdata, m_axis_config_tvalid,
        input  m_axis_data_tdata, m_axis_data_tvalid,
        input  m_axis_data_tlast
    );
endinterface

// File: rtl/axis_skid_fifo2.sv
// Two-entry registered FIFO with a one-bit sideband per entry.
// Overflow is prevented by the caller's read-credit accounting.
module axis_skid_fifo2 #(
    parameter int W = 32
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_pop,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head,
    output logic         o_last
);
    logic [W-1:0] r_data [2];
    logic [1:0]   r_last;
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_count;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_count   <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wr] <= i_data;
                r_last[r_wr] <= i_last;
                r_wr         <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_data[r_rd];
    assign o_last  = r_last[r_rd];
endmodule

// File: rtl/fft_sample_streamer.sv
// Streams sample memory into the FFT core data port after one config beat.
// Reads are credit-limited so the 2-entry FIFO absorbs any back-pressure.
module fft_sample_streamer
    import fft_stream_pkg::*;
#(
    parameter int         FRAME_LEN = DEF_FRAME_LEN,
    parameter int         SAMPLE_W  = 16,
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] CFG_WORD  = DEF_CFG_WORD
) (
    input logic ap_clk,
    input logic ap_rst_n,
    fft_sample_streamer_if.master bus
);
    localparam int CNT_W = $clog2(FRAME_LEN);

    state_e              r_state;
    state_e              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_rd_pend;
    logic                r_rd_last;
    logic                w_start_ok;
    logic                w_cfg_valid;
    logic                w_cfg_hs;
    logic                w_room;
    logic                w_issue;
    logic                w_last_rd;
    logic                w_valid;
    logic                w_pop;
    logic                w_head_last;
    logic [1:0]          w_count;
    logic [31:0]         w_head_re;
    logic [31:0]         w_push_re;
    logic signed [SAMPLE_W-1:0] w_sample;

    assign w_start_ok  = (r_state == S_IDLE) && bus.start;
    assign w_cfg_valid = (r_state == S_CFG);
    assign w_cfg_hs    = w_cfg_valid && bus.m_axis_config_tready;
    assign w_valid     = (w_count != 2'd0);
    assign w_pop       = w_valid && bus.m_axis_data_tready;
    assign w_last_rd   = (r_addr == r_last_addr);

    // Occupancy plus the read in flight, minus this cycle's pop, must stay below 2.
    assign w_room  = (3'(w_count) + 3'(r_rd_pend) - 3'(w_pop)) < 3'd2;
    assign w_issue = (r_state == S_STREAM) && w_room;

    assign w_sample  = bus.mem_rdata;
    assign w_push_re = {{(32-SAMPLE_W){w_sample[SAMPLE_W-1]}}, w_sample};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.num_frames == 8'd0) ? S_DONE : S_CFG;
                end
            end
            S_CFG:    if (w_cfg_hs) w_next = S_STREAM;
            S_STREAM: if (w_issue && w_last_rd) w_next = S_FLUSH;
            S_FLUSH:  if (w_pop && w_head_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_beat_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= w_issue;
            r_rd_last <= w_issue && w_last_rd;
            if (w_start_ok) begin
                r_addr      <= '0;
                r_last_addr <= ADDR_W'(32'(bus.num_frames) * FRAME_LEN - 1);
                r_beat_cnt  <= '0;
            end else begin
                if (w_issue && !w_last_rd) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    axis_skid_fifo2 #(.W(32)) u_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .i_push   (r_rd_pend),
        .i_data   (w_push_re),
        .i_last   (r_rd_last),
        .i_pop    (w_pop),
        .o_count  (w_count),
        .o_head   (w_head_re),
        .o_last   (w_head_last)
    );

    assign bus.busy                 = (r_state != S_IDLE);
    assign bus.done                 = (r_state == S_DONE);
    assign bus.mem_en               = w_issue;
    assign bus.mem_addr             = r_addr;
    assign bus.m_axis_config_tvalid = w_cfg_valid;
    assign bus.m_axis_config_tdata  = w_cfg_valid ? CFG_WORD : 8'h00;
    assign bus.m_axis_data_tvalid   = w_valid;
    assign bus.m_axis_data_tdata    = pack_beat(w_head_re);
    assign bus.m_axis_data_tlast    = w_valid && (r_beat_cnt == CNT_W'(FRAME_LEN - 1));
endmodule

// File: tb/tb_fft_sample_streamer.sv
// Bench for fft_sample_streamer: table of runs checked against a frame model,
// plus hand-written zero-frame, mid-run reset and start-while-busy sequences.
module tb_fft_sample_streamer;
    import fft_stream_pkg::*;

    localparam int FL = 8192;

    typedef struct {
        int nf;
        int pat;
        bit rnd;
        int stall;
        bit poke;
        int e_beats;
        int e_addr;
        int e_tl;
    } vec_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    fft_sample_streamer_if #(.ADDR_W(16), .SAMPLE_W(16)) bus ();

    fft_sample_streamer #(
        .FRAME_LEN(FL), .SAMPLE_W(16), .ADDR_W(16), .CFG_WORD(8'h01)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    logic [15:0] mem [65536];
    bit   rnd_mode;
    vec_t tbl [5];
    int   n_cmp, n_err;

    int cyc, beat_i, bad_beats, bad_idx, tl_cnt, cfg_cnt, cfg_cyc;
    int first_v_cyc, first_en_cyc, early_en, addr_bad, stall_viol;
    int max_out, issued, popped, done_cyc, done_cnt, last_beat_cyc;
    int cfg_vseen, dv_seen, cfg_word_bad, n_en, last_addr;
    bit cfg_seen, prev_v, prev_r, prev_l;
    logic [63:0] prev_d, b0, b1, bad_got, bad_exp;

    always @(posedge ap_clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge ap_clk) begin
        #1;
        bus.m_axis_data_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: reference frame model indexed by beat number within the run.
    always @(negedge ap_clk) begin
        logic [15:0] s;
        logic [63:0] ed;
        logic el;
        cyc++;
        if (!ap_rst_n) begin
            cfg_seen = 0;
            prev_v   = 0;
            issued   = 0;
            popped   = 0;
        end else begin
            if (bus.start && !bus.busy) begin
                beat_i = 0; bad_beats = 0; bad_idx = -1; tl_cnt = 0;
                cfg_cnt = 0; cfg_cyc = -1; first_v_cyc = -1;
                first_en_cyc = -1; early_en = 0; addr_bad = 0;
                stall_viol = 0; max_out = 0; issued = 0; popped = 0;
                done_cyc = -1; done_cnt = 0; last_beat_cyc = -1;
                cfg_vseen = 0; dv_seen = 0; cfg_word_bad = 0; n_en = 0;
                cfg_seen = 0; b0 = '0; b1 = '0; last_addr = 0;
            end
            if (bus.mem_en) begin
                if (!cfg_seen) early_en++;
                else begin
                    if (n_en == 0) begin
                        first_en_cyc = cyc;
                        if (bus.mem_addr != 16'd0) addr_bad++;
                    end else if (int'(bus.mem_addr) != last_addr + 1) addr_bad++;
                    last_addr = int'(bus.mem_addr);
                    n_en++;
                    issued++;
                end
            end
            if (bus.m_axis_config_tvalid) begin
                cfg_vseen++;
                if (bus.m_axis_config_tdata !== 8'h01) cfg_word_bad++;
                if (bus.m_axis_config_tready) begin
                    cfg_cnt++;
                    cfg_cyc  = cyc;
                    cfg_seen = 1;
                end
            end
            if (bus.m_axis_data_tvalid) begin
                dv_seen++;
                if (first_v_cyc < 0) first_v_cyc = cyc;
            end
            if (prev_v && !prev_r) begin
                if (!bus.m_axis_data_tvalid || bus.m_axis_data_tdata !== prev_d ||
                    bus.m_axis_data_tlast !== prev_l) stall_viol++;
            end
            if (bus.m_axis_data_tvalid && bus.m_axis_data_tready) begin
                s  = mem[16'(beat_i)];
                ed = {32'h0, {16{s[15]}}, s};
                el = ((beat_i % FL) == FL - 1);
                if (bus.m_axis_data_tdata !== ed || bus.m_axis_data_tlast !== el) begin
                    if (bad_beats == 0) begin
                        bad_idx = beat_i;
                        bad_got = bus.m_axis_data_tdata;
                        bad_exp = ed;
                    end
                    bad_beats++;
                end
                if (beat_i == 0) b0 = bus.m_axis_data_tdata;
                if (beat_i == 1) b1 = bus.m_axis_data_tdata;
                if (bus.m_axis_data_tlast) tl_cnt++;
                beat_i++;
                popped++;
                last_beat_cyc = cyc;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            prev_v = bus.m_axis_data_tvalid;
            prev_r = bus.m_axis_data_tready;
            prev_d = bus.m_axis_data_tdata;
            prev_l = bus.m_axis_data_tlast;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_start(input int nf);
        bus.num_frames = 8'(nf);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run(input vec_t v);
        bit got;
        for (int i = 0; i < v.e_beats; i++) begin
            case (v.pat)
                0: mem[i] = 16'(i);
                1: mem[i] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
                default: mem[i] = 16'($urandom);
            endcase
        end
        rnd_mode = v.rnd;
        bus.m_axis_config_tready = (v.stall == 0);
        pulse_start(v.nf);
        check("busy_cycle1", longint'(bus.busy), 1);
        check("cfg_valid_cycle1", longint'(bus.m_axis_config_tvalid), 1);
        for (int i = 0; i < v.stall; i++) step();
        bus.m_axis_config_tready = 1'b1;
        got = 0;
        for (int k = 0; k < v.nf * FL * 4 + 200; k++) begin
            step();
            if (v.poke && k == 1000) begin
                bus.num_frames = 8'd5;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                got = 1;
                break;
            end
        end
        bus.start = 1'b0;
        @(negedge ap_clk);
        #1;
        check("done_seen", longint'(got), 1);
        check("beat_count", beat_i, v.e_beats);
        if (bad_beats != 0)
            $display("first bad beat %0d got %h exp %h", bad_idx, bad_got, bad_exp);
        check("beat_data", bad_beats, 0);
        check("tlast_count", tl_cnt, v.e_tl);
        check("final_addr", longint'(bus.mem_addr), v.e_addr);
        check("addr_sequence", addr_bad, 0);
        check("cfg_handshakes", cfg_cnt, 1);
        check("cfg_word", cfg_word_bad, 0);
        check("mem_en_before_cfg", early_en, 0);
        check("mem_en_latency", first_en_cyc - cfg_cyc, 1);
        check("tvalid_latency", first_v_cyc - cfg_cyc, 3);
        check("stall_stability", stall_viol, 0);
        check("outstanding_le2", longint'(max_out <= 2), 1);
        check("done_after_last", done_cyc - last_beat_cyc, 1);
        check("done_pulses", done_cnt, 1);
        if (!v.rnd) check("last_beat_cycle", last_beat_cyc - cfg_cyc, 2 + v.e_beats);
        if (v.pat == 1) begin
            check("sext_neg", longint'(b0), 64'h00000000FFFF8000);
            check("sext_pos", longint'(b1), 64'h0000000000007FFF);
        end
        bus.m_axis_config_tready = 1'b0;
        rnd_mode = 0;
        step();
        check("busy_after_run", longint'(bus.busy), 0);
    endtask

    initial begin
        int k;
        bit got;
        n_cmp = 0;
        n_err = 0;
        bus.start = 1'b0;
        bus.num_frames = 8'd0;
        bus.m_axis_config_tready = 1'b0;
        rnd_mode = 0;
        tbl[0] = '{1, 0, 1'b0, 0,  1'b1, 8192,  8191,  1};
        tbl[1] = '{2, 1, 1'b0, 0,  1'b0, 16384, 16383, 2};
        tbl[2] = '{1, 2, 1'b1, 0,  1'b0, 8192,  8191,  1};
        tbl[3] = '{1, 0, 1'b0, 20, 1'b0, 8192,  8191,  1};
        tbl[4] = '{1, 2, 1'b0, 0,  1'b0, 8192,  8191,  1};

        ap_rst_n = 1'b1;
        #1 ap_rst_n = 1'b0;
        #2;
        check("reset_ctl", longint'({bus.busy, bus.done, bus.mem_en,
              bus.m_axis_config_tvalid, bus.m_axis_data_tvalid,
              bus.m_axis_data_tlast, bus.mem_addr}), 0);
        check("reset_tdata", longint'(bus.m_axis_data_tdata), 0);
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        step();

        for (int t = 0; t < 4; t++) run(tbl[t]);

        bus.m_axis_config_tready = 1'b1;
        pulse_start(0);
        k = 1;
        got = 0;
        while (k <= 4) begin
            if (bus.done) begin
                got = 1;
                break;
            end
            step();
            k++;
        end
        check("nf0_done_seen", longint'(got), 1);
        check("nf0_done_within2", longint'(k <= 2), 1);
        repeat (3) step();
        check("nf0_cfg_valid", cfg_vseen, 0);
        check("nf0_data_valid", dv_seen, 0);
        check("nf0_mem_en", early_en + n_en, 0);
        check("nf0_done_pulses", done_cnt, 1);
        check("nf0_busy_after", longint'(bus.busy), 0);

        for (int i = 0; i < FL; i++) mem[i] = 16'(i);
        pulse_start(1);
        repeat (3000) step();
        check("mid_run_valid", longint'(bus.m_axis_data_tvalid), 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("midrst_ctl", longint'({bus.busy, bus.done, bus.mem_en,
              bus.m_axis_config_tvalid, bus.m_axis_data_tvalid,
              bus.m_axis_data_tlast, bus.mem_addr}), 0);
        check("midrst_tdata", longint'(bus.m_axis_data_tdata), 0);
        bus.m_axis_config_tready = 1'b0;
        step();
        ap_rst_n = 1'b1;
        step();
        run(tbl[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
